// File: rtl/tpu_pkg.sv
// Shared scheduler types: source/destination operand fields, slot record, map entry.
// Latency: n/a (types and pure helper function only).
// Backpressure: n/a.
package tpu_pkg;

  localparam int TPU_INST_W  = 22;
  localparam int TPU_PREG_W  = 6;
  localparam int TPU_ENTRIES = 4;
  localparam int TPU_IDX_W   = 2;

  // Source operand as carried from rename: vld=0 means the operand is unused.
  typedef struct packed {
    logic                  vld;
    logic                  rdy;
    logic [TPU_PREG_W-1:0] preg;
  } tpu_src_t;

  // Destination operand.
  typedef struct packed {
    logic                  vld;
    logic [TPU_PREG_W-1:0] preg;
  } tpu_dst_t;

  // Rename map entry as kept by the tpu_lin slices.
  typedef struct packed {
    logic                  rdy;
    logic [TPU_PREG_W-1:0] preg;
  } tpu_map_t;

  // Payload held per scheduler slot (valid bit is kept separately).
  typedef struct packed {
    logic [TPU_INST_W-1:0] inst;
    tpu_src_t              src1;
    tpu_src_t              src2;
    tpu_dst_t              dst;
  } tpu_slot_t;

  localparam int TPU_SLOT_W = $bits(tpu_slot_t);

  // An unused source never blocks issue.
  function automatic logic src_ready(tpu_src_t s);
    return !s.vld || s.rdy;
  endfunction

  // Apply a wakeup broadcast to one source field.
  function automatic tpu_src_t src_wake(tpu_src_t s, logic wv, logic [TPU_PREG_W-1:0] wp);
    tpu_src_t r;
    r = s;
    if (wv && s.vld && (s.preg == wp)) r.rdy = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tpu_age_sel.sv
// Rotating-priority picker: first set request at or after head_idx, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is recomputed every cycle from the request vector.
module tpu_age_sel #(
  parameter int ENTRIES  = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [ENTRIES-1:0]  req,
  input  logic [IDX_BITS-1:0] head_idx,
  output logic [ENTRIES-1:0]  gnt_oh,
  output logic [IDX_BITS-1:0] gnt_idx,
  output logic                gnt_any
);

  logic [IDX_BITS-1:0] scan_idx;

  // Walk slots oldest-first starting from head; the first requester wins.
  always_comb begin
    gnt_oh   = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      scan_idx = head_idx + IDX_BITS'(k);
      if (!gnt_any && req[scan_idx]) begin
        gnt_any          = 1'b1;
        gnt_idx          = scan_idx;
        gnt_oh[scan_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tpu_issue_sched.sv
// Issue scheduler: circular buffer of renamed ops, wakeup snoop, oldest-ready single issue.
// Latency: alloc to issue 1 cycle when sources ready; wakeup to selectable 1 cycle.
// Backpressure: alloc_rdy drops when all slots between head and tail are in use; iss_vld holds until iss_ack.
module tpu_issue_sched
  import tpu_pkg::*;
#(
  parameter int INST_WIDTH = TPU_INST_W,
  parameter int PREG_BITS  = TPU_PREG_W,
  parameter int ENTRIES    = TPU_ENTRIES,
  parameter int IDX_BITS   = TPU_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alloc_vld,
  output logic                  alloc_rdy,
  input  logic [INST_WIDTH-1:0] alloc_inst,
  input  logic [PREG_BITS+1:0]  alloc_src1,
  input  logic [PREG_BITS+1:0]  alloc_src2,
  input  logic [PREG_BITS:0]    alloc_dst,
  input  logic                  wk_vld,
  input  logic [PREG_BITS-1:0]  wk_preg,
  output logic                  iss_vld,
  input  logic                  iss_ack,
  output logic [INST_WIDTH-1:0] iss_inst,
  output logic [IDX_BITS-1:0]   iss_idx,
  output logic [PREG_BITS:0]    iss_dst,
  output logic [IDX_BITS:0]     occ
);

  localparam logic [IDX_BITS:0] PTR_ONE = (IDX_BITS+1)'(1);
  localparam logic [IDX_BITS:0] PTR_CAP = (IDX_BITS+1)'(ENTRIES);

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [IDX_BITS:0]   head_q, tail_q, occ_w;
  logic [IDX_BITS-1:0] head_idx, tail_idx;
  logic [ENTRIES-1:0]  slot_vld_q;
  tpu_slot_t           slot_q [ENTRIES];

  logic [ENTRIES-1:0]  req, gnt_oh, clr_mask, set_mask;
  logic [IDX_BITS-1:0] gnt_idx;
  logic                gnt_any;
  logic                alloc_fire, iss_fire, head_step;
  tpu_slot_t           new_slot;

  assign head_idx   = head_q[IDX_BITS-1:0];
  assign tail_idx   = tail_q[IDX_BITS-1:0];
  assign occ_w      = tail_q - head_q;
  assign occ        = occ_w;
  assign alloc_rdy  = occ_w < PTR_CAP;
  assign alloc_fire = alloc_vld && alloc_rdy;
  assign iss_fire   = gnt_any && iss_ack;
  // Head only advances over a slot that has already issued.
  assign head_step  = !slot_vld_q[head_idx] && (head_q != tail_q);

  // Incoming op with same-cycle wakeup bypassed into its source ready bits.
  always_comb begin
    new_slot      = '0;
    new_slot.inst = alloc_inst;
    new_slot.src1 = src_wake(tpu_src_t'(alloc_src1), wk_vld, wk_preg);
    new_slot.src2 = src_wake(tpu_src_t'(alloc_src2), wk_vld, wk_preg);
    new_slot.dst  = tpu_dst_t'(alloc_dst);
  end

  // Issue candidates: valid slots with both sources ready.
  always_comb begin
    req = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      req[i] = slot_vld_q[i] && src_ready(slot_q[i].src1) && src_ready(slot_q[i].src2);
    end
  end

  tpu_age_sel #(
    .ENTRIES  (ENTRIES),
    .IDX_BITS (IDX_BITS)
  ) u_age_sel (
    .req      (req),
    .head_idx (head_idx),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // Valid-bit updates for this cycle's issue and allocation.
  always_comb begin
    clr_mask = iss_fire ? gnt_oh : '0;
    set_mask = '0;
    if (alloc_fire) set_mask[tail_idx] = 1'b1;
  end

  assign iss_vld  = gnt_any;
  assign iss_idx  = gnt_any ? gnt_idx : '0;
  assign iss_inst = gnt_any ? slot_q[gnt_idx].inst : '0;
  assign iss_dst  = gnt_any ? slot_q[gnt_idx].dst : '0;

  // Slot storage, wakeup snoop and pointer maintenance; flush wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      slot_vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) slot_q[i] <= '0;
    end else if (flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      slot_vld_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (slot_vld_q[i]) begin
          slot_q[i].src1 <= src_wake(slot_q[i].src1, wk_vld, wk_preg);
          slot_q[i].src2 <= src_wake(slot_q[i].src2, wk_vld, wk_preg);
        end
      end
      // The tail slot is never valid while alloc_rdy is high, so this never collides with the snoop above.
      if (alloc_fire) begin
        slot_q[tail_idx] <= new_slot;
        tail_q           <= tail_q + PTR_ONE;
      end
      slot_vld_q <= (slot_vld_q & ~clr_mask) | set_mask;
      if (head_step) head_q <= head_q + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_tpu_issue_sched.sv
module tb_tpu_issue_sched;

  localparam int IW = 22;
  localparam int PB = 6;
  localparam int NE = 4;
  localparam int IB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          alloc_vld = 1'b0;
  logic          alloc_rdy;
  logic [IW-1:0] alloc_inst = '0;
  logic [PB+1:0] alloc_src1 = '0;
  logic [PB+1:0] alloc_src2 = '0;
  logic [PB:0]   alloc_dst = '0;
  logic          wk_vld = 1'b0;
  logic [PB-1:0] wk_preg = '0;
  logic          iss_vld;
  logic          iss_ack = 1'b0;
  logic [IW-1:0] iss_inst;
  logic [IB-1:0] iss_idx;
  logic [PB:0]   iss_dst;
  logic [IB:0]   occ;

  int n_tests = 0;
  int n_fail  = 0;

  tpu_issue_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .alloc_vld  (alloc_vld),
    .alloc_rdy  (alloc_rdy),
    .alloc_inst (alloc_inst),
    .alloc_src1 (alloc_src1),
    .alloc_src2 (alloc_src2),
    .alloc_dst  (alloc_dst),
    .wk_vld     (wk_vld),
    .wk_preg    (wk_preg),
    .iss_vld    (iss_vld),
    .iss_ack    (iss_ack),
    .iss_inst   (iss_inst),
    .iss_idx    (iss_idx),
    .iss_dst    (iss_dst),
    .occ        (occ)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight ops in program order, each tagged with its slot number.
  typedef struct {
    int            slot;
    logic [IW-1:0] inst;
    bit            v1, r1, v2, r2;
    int            p1, p2;
    logic [PB:0]   dst;
    bit            issued;
  } rec_t;

  rec_t q[$];
  int   tail_slot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int i = 0; i < q.size(); i++) begin
      if (!q[i].issued && (!q[i].v1 || q[i].r1) && (!q[i].v2 || q[i].r2)) return i;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    q.delete();
    tail_slot = 0;
  endfunction

  task automatic check_model();
    int w;
    w = m_winner();
    chk("alloc_rdy", 32'(alloc_rdy), 32'(q.size() < NE));
    chk("occ", 32'(occ), 32'(q.size()));
    chk("iss_vld", 32'(iss_vld), 32'(w >= 0));
    chk("iss_idx", 32'(iss_idx), (w >= 0) ? 32'(q[w].slot) : 32'd0);
    chk("iss_inst", 32'(iss_inst), (w >= 0) ? 32'(q[w].inst) : 32'd0);
    chk("iss_dst", 32'(iss_dst), (w >= 0) ? 32'(q[w].dst) : 32'd0);
  endtask

  // Advance the model by one clock edge given the inputs driven this cycle.
  function automatic void m_step(bit av, logic [IW-1:0] inst, logic [PB+1:0] s1, logic [PB+1:0] s2,
                                 logic [PB:0] d, bit wv, logic [PB-1:0] wp, bit ack, bit fl);
    int   w;
    bit   retire, can_alloc;
    rec_t r;
    if (fl) begin
      m_reset();
      return;
    end
    w         = m_winner();
    can_alloc = q.size() < NE;
    retire    = (q.size() > 0) && q[0].issued;
    if (wv) begin
      foreach (q[i]) begin
        if (q[i].v1 && q[i].p1 == int'(wp)) q[i].r1 = 1;
        if (q[i].v2 && q[i].p2 == int'(wp)) q[i].r2 = 1;
      end
    end
    if (ack && w >= 0) q[w].issued = 1;
    if (av && can_alloc) begin
      r.slot   = tail_slot;
      r.inst   = inst;
      r.v1     = s1[PB+1];
      r.p1     = int'(s1[PB-1:0]);
      r.r1     = s1[PB] || (wv && r.p1 == int'(wp));
      r.v2     = s2[PB+1];
      r.p2     = int'(s2[PB-1:0]);
      r.r2     = s2[PB] || (wv && r.p2 == int'(wp));
      r.dst    = d;
      r.issued = 0;
      q.push_back(r);
      tail_slot = (tail_slot + 1) % NE;
    end
    if (retire) void'(q.pop_front());
  endfunction

  task automatic drive_idle();
    alloc_vld  = 1'b0;
    alloc_inst = '0;
    alloc_src1 = '0;
    alloc_src2 = '0;
    alloc_dst  = '0;
    wk_vld     = 1'b0;
    wk_preg    = '0;
    iss_ack    = 1'b0;
    flush      = 1'b0;
  endtask

  // One clock: check outputs against the model, drive inputs, step model, take the edge, go idle.
  task automatic cycle(input bit av, input logic [IW-1:0] inst, input logic [PB+1:0] s1,
                       input logic [PB+1:0] s2, input logic [PB:0] d, input bit wv,
                       input logic [PB-1:0] wp, input bit ack, input bit fl);
    @(negedge clk);
    check_model();
    alloc_vld  = av;
    alloc_inst = inst;
    alloc_src1 = s1;
    alloc_src2 = s2;
    alloc_dst  = d;
    wk_vld     = wv;
    wk_preg    = wp;
    iss_ack    = ack;
    flush      = fl;
    m_step(av, inst, s1, s2, d, wv, wp, ack, fl);
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(alloc_rdy), 32'd1);
    chk({tag, "_vld"}, 32'(iss_vld), 32'd0);
    chk({tag, "_occ"}, 32'(occ), 32'd0);
    chk({tag, "_idx"}, 32'(iss_idx), 32'd0);
    chk({tag, "_dst"}, 32'(iss_dst), 32'd0);
    chk({tag, "_inst"}, 32'(iss_inst), 32'd0);
  endtask

  initial begin
    int            ack_pct;
    logic [PB+1:0] s1, s2;
    logic [PB:0]   d;

    drive_idle();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    idle(2);
    check_reset_vals("idle");

    // Single ready op issues the cycle after allocation.
    cycle(1, 22'h00_1234, 8'hC5, 8'h00, 7'h49, 0, '0, 0, 0);
    chk("t2_vld", 32'(iss_vld), 32'd1);
    chk("t2_idx", 32'(iss_idx), 32'd0);
    chk("t2_dst", 32'(iss_dst), 32'h49);
    cycle(0, '0, '0, '0, '0, 0, '0, 1, 0);
    chk("t2_occ_after_ack", 32'(occ), 32'd1);
    chk("t2_vld_after_ack", 32'(iss_vld), 32'd0);
    idle(1);
    chk("t2_occ_drained", 32'(occ), 32'd0);

    // Younger ready op bypasses an older waiting one; wakeup frees the older one a cycle later.
    cycle(1, 22'h0000A, 8'h8C, 8'h00, 7'h41, 0, '0, 0, 0);
    cycle(1, 22'h0000B, 8'h00, 8'h00, 7'h42, 0, '0, 0, 0);
    chk("t3_young_vld", 32'(iss_vld), 32'd1);
    chk("t3_young_idx", 32'(iss_idx), 32'd2);
    cycle(0, '0, '0, '0, '0, 1, 6'd12, 1, 0);
    chk("t3_old_idx", 32'(iss_idx), 32'd1);
    chk("t3_old_vld", 32'(iss_vld), 32'd1);
    cycle(0, '0, '0, '0, '0, 0, '0, 1, 0);
    idle(2);
    chk("t3_empty", 32'(occ), 32'd0);

    // Fill all slots with waiting ops; a fifth offer is refused.
    for (int i = 0; i < NE; i++) cycle(1, 22'(100 + i), 8'(8'h80 | (30 + i)), 8'h00, 7'(i), 0, '0, 0, 0);
    chk("t4_full_occ", 32'(occ), 32'd4);
    chk("t4_full_rdy", 32'(alloc_rdy), 32'd0);
    cycle(1, 22'd999, 8'h00, 8'h00, 7'h00, 0, '0, 0, 0);
    chk("t4_refused_occ", 32'(occ), 32'd4);
    for (int i = 0; i < NE; i++) cycle(0, '0, '0, '0, '0, 1, 6'(30 + i), 0, 0);
    cycle(0, '0, '0, '0, '0, 0, '0, 1, 0);
    chk("t4_ack_no_rdy", 32'(alloc_rdy), 32'd0);
    idle(1);
    chk("t4_rdy_back", 32'(alloc_rdy), 32'd1);
    chk("t4_occ3", 32'(occ), 32'd3);
    for (int i = 0; i < 8; i++) cycle(0, '0, '0, '0, '0, 0, '0, 1, 0);

    // Same-cycle wakeup bypass on allocation.
    cycle(1, 22'h2A2A2, 8'h00, 8'h94, 7'h55, 1, 6'd20, 0, 0);
    chk("t5_vld", 32'(iss_vld), 32'd1);
    chk("t5_inst", 32'(iss_inst), 32'h2A2A2);
    cycle(0, '0, '0, '0, '0, 0, '0, 1, 0);
    idle(2);

    // Flush overrides ack, alloc and wakeup.
    for (int i = 0; i < 3; i++) cycle(1, 22'(200 + i), 8'h00, 8'h00, 7'(i), 0, '0, 0, 0);
    cycle(1, 22'd777, 8'h00, 8'h00, 7'h11, 1, 6'd3, 1, 1);
    chk("t6_occ", 32'(occ), 32'd0);
    chk("t6_vld", 32'(iss_vld), 32'd0);
    idle(1);

    // Randomized traffic with a mid-stream async reset.
    ack_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) ack_pct = $urandom_range(0, 100);
      s1 = {1'($urandom), 1'($urandom), 6'($urandom_range(0, 7))};
      s2 = {1'($urandom), 1'($urandom), 6'($urandom_range(0, 7))};
      d  = 7'($urandom);
      cycle(($urandom % 10) < 6, 22'($urandom), s1, s2, d, 1'($urandom),
            6'($urandom_range(0, 7)), ($urandom % 100) < ack_pct, ($urandom % 64) == 0);
      if (n == 1500) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
